// File: rtl/comparator_pkg.sv
// Shared definitions for the serial and parallel magnitude comparators:
// FSM state type and the common result encoding.
package comparator_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } cmp_state_e;

  localparam int unsigned RES_W = 2;

  localparam logic [RES_W-1:0] RES_EQ = 2'd0;
  localparam logic [RES_W-1:0] RES_GT = 2'd1;
  localparam logic [RES_W-1:0] RES_SM = 2'd2;

  // Expand a result code into the {eq, gt, sm} flag triple.
  function automatic logic [2:0] res_flags(input logic [RES_W-1:0] res);
    logic [2:0] flags;
    flags = 3'b000;
    case (res)
      RES_EQ:  flags = 3'b100;
      RES_GT:  flags = 3'b010;
      RES_SM:  flags = 3'b001;
      default: flags = 3'b000;
    endcase
    return flags;
  endfunction

endpackage

// File: rtl/comparator_serial_cnt.sv
// Bit-position counter for the serial comparator: counts consumed bit pairs
// and flags the final position; saturates there so it never wraps.
module comparator_serial_cnt #(
  parameter int unsigned WIDTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic last_c
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  logic [CNT_W-1:0] cnt;

  assign last_c = (cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !last_c) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/comparator_serial.sv
// Bit-serial MSB-first magnitude comparator with a one-cycle done pulse.
// Define COMPARATOR_SERIAL_EARLY_DONE_EN to finish on the first differing pair.
module comparator_serial
  import comparator_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic bit_valid,
  input  logic a_bit,
  input  logic b_bit,
  output logic busy,
  output logic done,
  output logic eq,
  output logic gt,
  output logic sm
);

  cmp_state_e state;

  logic decided;
  logic gt_n;
  logic sm_n;

  logic             cnt_clr_c;
  logic             cnt_en_c;
  logic             last_c;
  logic             new_decide_c;
  logic             decided_nx_c;
  logic             gt_nx_c;
  logic             sm_nx_c;
  logic             finish_c;
  logic [RES_W-1:0] res_c;

  assign cnt_clr_c = (state == IDLE) && start;
  assign cnt_en_c  = (state == SHIFT) && bit_valid;

  comparator_serial_cnt #(
    .WIDTH (WIDTH)
  ) u_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr    (cnt_clr_c),
    .en     (cnt_en_c),
    .last_c (last_c)
  );

  // The first differing pair decides; later pairs only advance the count.
  assign new_decide_c = cnt_en_c && !decided && (a_bit ^ b_bit);
  assign decided_nx_c = decided | new_decide_c;
  assign gt_nx_c      = new_decide_c ? a_bit : gt_n;
  assign sm_nx_c      = new_decide_c ? b_bit : sm_n;

`ifdef COMPARATOR_SERIAL_EARLY_DONE_EN
  assign finish_c = cnt_en_c && (last_c || new_decide_c);
`else
  assign finish_c = cnt_en_c && last_c;
`endif

  // Result includes the pair consumed this cycle, so DONE shows it at once.
  always_comb begin
    res_c = RES_EQ;
    if (decided_nx_c) begin
      res_c = gt_nx_c ? RES_GT : RES_SM;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      eq      <= 1'b0;
      gt      <= 1'b0;
      sm      <= 1'b0;
      decided <= 1'b0;
      gt_n    <= 1'b0;
      sm_n    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state        <= SHIFT;
            busy         <= 1'b1;
            decided      <= 1'b0;
            gt_n         <= 1'b0;
            sm_n         <= 1'b0;
            {eq, gt, sm} <= 3'b000;
          end
        end
        SHIFT: begin
          if (cnt_en_c) begin
            decided <= decided_nx_c;
            gt_n    <= gt_nx_c;
            sm_n    <= sm_nx_c;
          end
          if (finish_c) begin
            state        <= DONE;
            done         <= 1'b1;
            {eq, gt, sm} <= res_flags(res_c);
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_comparator_serial.sv
// Directed bench for comparator_serial (WIDTH=4) against a word-level model.
module tb_comparator_serial;

  localparam int unsigned W = 4;
`ifdef COMPARATOR_SERIAL_EARLY_DONE_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, start, bit_valid, a_bit, b_bit;
  logic busy, done, eq, gt, sm;

  comparator_serial #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .bit_valid (bit_valid),
    .a_bit     (a_bit),
    .b_bit     (b_bit),
    .busy      (busy),
    .done      (done),
    .eq        (eq),
    .gt        (gt),
    .sm        (sm)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Model state: window of the current comparison and the held/new results.
  int         m_start = -1;
  int         m_done  = -1;
  logic [2:0] prev_res = 3'b000;
  logic [2:0] cur_res  = 3'b000;
  int         last_done_cyc = -1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // {eq,gt,sm} from plain integer comparison.
  function automatic logic [2:0] model_res(input logic [W-1:0] a, input logic [W-1:0] b);
    if (a == b) return 3'b100;
    if (a > b)  return 3'b010;
    return 3'b001;
  endfunction

  // Number of pairs the DUT consumes before finishing.
  function automatic int model_pairs(input logic [W-1:0] a, input logic [W-1:0] b);
    if (!EARLY || a == b) return W;
    for (int i = 0; i < W; i++) begin
      if (a[W-1-i] != b[W-1-i]) return i + 1;
    end
    return W;
  endfunction

  // Per-cycle compare of all outputs against the model window.
  initial begin
    logic       e_busy, e_done;
    logic [2:0] e_res;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (m_start < 0 || cyc < m_start) begin
        e_busy = 1'b0; e_done = 1'b0; e_res = prev_res;
      end else if (cyc < m_done) begin
        e_busy = 1'b1; e_done = 1'b0; e_res = 3'b000;
      end else if (cyc == m_done) begin
        e_busy = 1'b1; e_done = 1'b1; e_res = cur_res;
      end else begin
        e_busy = 1'b0; e_done = 1'b0; e_res = cur_res;
      end
      check("busy", int'(busy), int'(e_busy));
      check("done", int'(done), int'(e_done));
      check("result_eq_gt_sm", int'({eq, gt, sm}), int'(e_res));
      if (done) last_done_cyc = cyc;
    end
  end

  // One comparison; called at a negedge, returns at the negedge after DONE.
  task automatic run(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                     input int stall_after, input int stall_len, input bit bit_with_start,
                     input int repulse_at, input int abort_after,
                     input int lat_plain, input int lat_early, input logic [2:0] res_lit);
    int k, np, d, lat_lit;
    k  = cyc + 1;
    np = model_pairs(a, b);
    d  = k + np + ((stall_after >= 0 && np > stall_after) ? stall_len : 0);
    prev_res = cur_res;
    cur_res  = model_res(a, b);
    m_start  = k;
    m_done   = d;
    last_done_cyc = -1;
    start     = 1'b1;
    bit_valid = bit_with_start;
    a_bit     = 1'b1;
    b_bit     = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < int'(W); i++) begin
      if (i == abort_after) begin
        bit_valid = 1'b0;
        rst = 1'b1;
        m_start = -1;
        prev_res = 3'b000;
        cur_res = 3'b000;
        #1;
        check({name, "_rst_busy"}, int'(busy), 0);
        check({name, "_rst_done"}, int'(done), 0);
        check({name, "_rst_res"}, int'({eq, gt, sm}), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        return;
      end
      if (i == stall_after) begin
        bit_valid = 1'b0;
        repeat (stall_len) @(negedge clk);
      end
      start     = (i == repulse_at);
      bit_valid = 1'b1;
      a_bit     = a[W-1-i];
      b_bit     = b[W-1-i];
      @(negedge clk);
      start = 1'b0;
    end
    bit_valid = 1'b0;
    while (cyc < d + 1) @(negedge clk);
    lat_lit = EARLY ? lat_early : lat_plain;
    check({name, "_model_latency"}, d - k + 1, lat_lit);
    check({name, "_model_result"}, int'(cur_res), int'(res_lit));
    check({name, "_done_cycle"}, last_done_cyc, k + lat_lit - 1);
    check({name, "_held_result"}, int'({eq, gt, sm}), int'(res_lit));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; bit_valid = 1'b0; a_bit = 1'b0; b_bit = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_res", int'({eq, gt, sm}), 0);
    rst = 1'b0;
    @(negedge clk);

    run("gt_low",   4'b0011, 4'b0001, -1, 0, 1'b0, -1, -1, 5, 4, 3'b010);
    @(negedge clk);
    run("sm_msb",   4'b0011, 4'b1010, -1, 0, 1'b0, -1, -1, 5, 2, 3'b001);
    @(negedge clk);
    run("eq_stall", 4'b1001, 4'b1001,  1, 2, 1'b0, -1, -1, 7, 7, 3'b100);
    @(negedge clk);
    run("gt_repulse", 4'b1111, 4'b0000, -1, 0, 1'b0, 1, -1, 5, 2, 3'b010);
    run("b2b_sm",   4'b0000, 4'b1111, -1, 0, 1'b0, -1, -1, 5, 2, 3'b001);
    @(negedge clk);
    run("abort",    4'b1010, 4'b0011, -1, 0, 1'b0, -1, 2, 0, 0, 3'b000);
    run("after_rst", 4'b1010, 4'b0011, -1, 0, 1'b0, -1, -1, 5, 2, 3'b010);
    @(negedge clk);
    run("start_bit", 4'b0110, 4'b0101, -1, 0, 1'b1, -1, -1, 5, 4, 3'b010);
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

endmodule
